// File: rtl/kp_pkg.sv
// rtl/kp_pkg.sv - shared types, width helpers and priority encoder for the keypad front end
// Contents: kp_state_e debounce FSM states, MAX_KEYS/MAX_CODE_W widths,
//           cnt_w() counter-width helper, prio_encode() highest-index encoder.
package kp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DEB,
    HELD,
    REL_DEB
  } kp_state_e;

  localparam int MAX_KEYS   = 16;
  localparam int MAX_CODE_W = $clog2(MAX_KEYS);

  // Bits needed to hold values 0..max_val inclusive, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Highest set index wins; an all-zero vector encodes as 0.
  function automatic logic [MAX_CODE_W-1:0] prio_encode(input logic [MAX_KEYS-1:0] vec);
    logic [MAX_CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (vec[i]) code = MAX_CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider producing a one-cycle tick every DIV cycles
// Ports: clk      system clock
//        rst      asynchronous active-high reset
//        tick     registered pulse, high in the cycle the count wraps DIV-1 -> 0
module tick_divider #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  import kp_pkg::*;

  localparam int W = cnt_w(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;
  logic         wrap;

  always_comb begin
    wrap   = (cnt_q == W'(DIV - 1));
    cnt_d  = wrap ? '0 : cnt_q + W'(1);
    tick_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/keypad_encoder_gen.sv
// rtl/keypad_encoder_gen.sv - keypad synchroniser, priority encoder, debounce FSM, auto-repeat and pulse mux
// Ports: clk, rst        clock, asynchronous active-high reset
//        en              1 = tick drives pgt_1Hz, 0 = key_strobe drives pgt_1Hz
//        keys            raw active-high key lines, asynchronous to clk
//        D               code of the last accepted key
//        key_strobe      one-cycle pulse on press acceptance and each repeat
//        held, load      debounced key held / its complement
//        tick            divider pulse every DIV cycles
//        pgt_1Hz         registered en ? tick : key_strobe
module keypad_encoder_gen
  import kp_pkg::*;
#(
  parameter int NUM_KEYS    = 10,
  parameter int CODE_W      = 4,
  parameter int DEB_CYCLES  = 4,
  parameter int DIV         = 100,
  parameter int REPEAT_EN   = 0,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [CODE_W-1:0]   D,
  output logic                key_strobe,
  output logic                held,
  output logic                load,
  output logic                tick,
  output logic                pgt_1Hz
);

  localparam int DEB_W   = cnt_w(DEB_CYCLES);
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = cnt_w(RPT_MAX);

  logic [NUM_KEYS-1:0] ks1_q, ks_q;
  logic [MAX_KEYS-1:0] ks_ext;
  logic [CODE_W-1:0]   raw_code;
  logic                any_key;

  kp_state_e           state_q, state_d;
  logic [CODE_W-1:0]   cand_q, cand_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [DEB_W-1:0]    cnt_q, cnt_d;
  logic [RPT_W-1:0]    rcnt_q, rcnt_d, rcnt_next;
  logic                rate_q, rate_d;
  logic                strobe_q, strobe_d;
  logic                held_q, held_d;
  logic                pgt_q, pgt_d;
  logic                press_eval;

  tick_divider #(.DIV(DIV)) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign ks_ext   = MAX_KEYS'(ks_q);
  assign raw_code = CODE_W'(prio_encode(ks_ext));
  assign any_key  = |ks_q;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    rate_d     = rate_q;
    strobe_d   = 1'b0;
    press_eval = 1'b0;
    rcnt_next  = rcnt_q + RPT_W'(1);

    case (state_q)
      IDLE: begin
        if (any_key) begin
          cand_d     = raw_code;
          cnt_d      = DEB_W'(1);
          press_eval = 1'b1;
        end
      end
      PRESS_DEB: begin
        if (!any_key) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          // A different winning code restarts the stable count on that code.
          if (raw_code != cand_q) begin
            cand_d = raw_code;
            cnt_d  = DEB_W'(1);
          end else begin
            cnt_d = cnt_q + DEB_W'(1);
          end
          press_eval = 1'b1;
        end
      end
      HELD: begin
        if (!any_key) begin
          cnt_d = DEB_W'(1);
          if (DEB_CYCLES == 1) begin
            state_d = IDLE;
            rcnt_d  = '0;
            rate_d  = 1'b0;
          end else begin
            state_d = REL_DEB;
          end
        end else if (REPEAT_EN != 0) begin
          // First repeat after REPEAT_DLY, then every REPEAT_RATE cycles.
          if ((!rate_q && rcnt_next == RPT_W'(REPEAT_DLY)) ||
              ( rate_q && rcnt_next == RPT_W'(REPEAT_RATE))) begin
            strobe_d = 1'b1;
            rcnt_d   = '0;
            rate_d   = 1'b1;
          end else begin
            rcnt_d = rcnt_next;
          end
        end
      end
      REL_DEB: begin
        // Key came back before release was confirmed: resume holding, repeat timing frozen.
        if (any_key) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
          if (cnt_d == DEB_W'(DEB_CYCLES)) begin
            state_d = IDLE;
            cnt_d   = '0;
            rcnt_d  = '0;
            rate_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance compares the updated count, so DEB_CYCLES=1 accepts on first sight.
    if (press_eval) begin
      if (cnt_d == DEB_W'(DEB_CYCLES)) begin
        state_d  = HELD;
        code_d   = cand_d;
        strobe_d = 1'b1;
        cnt_d    = '0;
        rcnt_d   = '0;
        rate_d   = 1'b0;
      end else begin
        state_d = PRESS_DEB;
      end
    end

    held_d = (state_d == HELD) || (state_d == REL_DEB);
    pgt_d  = en ? tick : strobe_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks1_q    <= '0;
      ks_q     <= '0;
      state_q  <= IDLE;
      cand_q   <= '0;
      code_q   <= '0;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      rate_q   <= 1'b0;
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
      pgt_q    <= 1'b0;
    end else begin
      ks1_q    <= keys;
      ks_q     <= ks1_q;
      state_q  <= state_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      rate_q   <= rate_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
      pgt_q    <= pgt_d;
    end
  end

  assign D          = code_q;
  assign key_strobe = strobe_q;
  assign held       = held_q;
  assign load       = ~held_q;
  assign pgt_1Hz    = pgt_q;

endmodule

// File: doc/keypad_encoder_gen.md
Name: keypad_encoder_gen

Overview:
Parametrised next-generation keypad front end for the microwave controller. It priority-encodes an N-key one-hot-ish keypad, debounces press and release with a stable-count filter, and emits a one-cycle key strobe with optional typematic auto-repeat. A muxed pulse output selects between the key strobe and an internal divided tick, so the block drops in for the existing keypad/debounce/divider chain ahead of the load/counter logic.

Parameters:
NUM_KEYS, 10, number of keypad lines (2..16)
CODE_W, 4, width of encoded key code; must be at least clog2(NUM_KEYS)
DEB_CYCLES, 4, consecutive stable cycles required to accept a press or a release (1..255)
DIV, 100, tick period in clk cycles (2..65535)
REPEAT_EN, 0, 1 enables auto-repeat strobes while a key is held
REPEAT_DLY, 50, held cycles after acceptance before the first repeat strobe
REPEAT_RATE, 20, cycles between subsequent repeat strobes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  mode select: 1 = timer tick on pgt_1Hz, 0 = key strobe on pgt_1Hz
keys  in  NUM_KEYS  raw key lines, active high, asynchronous to clk
D  out  CODE_W  code of the accepted key; holds its value until the next acceptance
key_strobe  out  1  one-cycle pulse on press acceptance and on each repeat
held  out  1  high while a debounced key is held
load  out  1  high when no debounced key is held (equals not held)
tick  out  1  one-cycle pulse every DIV cycles
pgt_1Hz  out  1  en ? tick : key_strobe (registered, one cycle after the source)

Behaviour:
- Reset (async assert, sync release): D=0, key_strobe=0, held=0, load=1, tick=0, pgt_1Hz=0, divider count=0, FSM=IDLE, all counters=0.
- keys passes through a two-flop synchroniser. All decisions use the synchronised vector ks.
- Priority encode: raw_code = highest set index of ks. any = |ks.
- FSM states IDLE, PRESS_DEB, HELD, REL_DEB:
  - IDLE: when any=1, capture cand=raw_code, cnt=1, go to PRESS_DEB.
  - PRESS_DEB: if any=0, go to IDLE. If raw_code!=cand, set cand=raw_code and cnt=1. Otherwise cnt++. When cnt reaches DEB_CYCLES, set D<=cand, pulse key_strobe, go to HELD, and clear the repeat counter.
  - HELD: if any=0, set cnt=1 and go to REL_DEB. A code change while held is ignored; D is not updated.
  - REL_DEB: if any=1, return to HELD without a new strobe. Otherwise cnt++. When cnt reaches DEB_CYCLES, go to IDLE.
- Latency: press acceptance occurs DEB_CYCLES+2 cycles after keys goes stable (2 synchroniser cycles plus DEB_CYCLES). With DEB_CYCLES=1, a single-cycle stable code is accepted.
- held=1 in HELD and REL_DEB. load is the complement of held.
- Auto-repeat (REPEAT_EN=1 only): in HELD, rcnt increments each cycle.
  - At rcnt==REPEAT_DLY: pulse key_strobe and reset rcnt to 0 in "rate" phase.
  - In rate phase, pulse key_strobe each time rcnt reaches REPEAT_RATE.
  - rcnt freezes in REL_DEB and clears on leaving HELD for IDLE.
- Divider: free-running from reset, independent of en. tick is high exactly when the count wraps from DIV-1 to 0. The first tick occurs in cycle DIV after reset release.
- pgt_1Hz is registered. Toggling en affects only the mux; it never resets the divider or the FSM.
- Simultaneous keys: the highest index wins. Releasing the higher key during PRESS_DEB restarts debounce on the lower code.
- Reset asserted mid-press: everything returns to reset values immediately with no strobe. After release, a still-held key is debounced afresh.
- All counters are saturating-safe: widths are sized from the parameters, and no wrap occurs before the compare.

Decomposition:
- Shared package kp_pkg:
  - FSM state enum (IDLE, PRESS_DEB, HELD, REL_DEB);
  - clog2-based width constants;
  - function prio_encode(vector) returning the code.
- One natural sub-module: tick_divider (parametrised DIV, clk, rst, tick out), reusable by the cooking timer.
- The synchroniser, FSM and repeat logic stay in the top module.

Test Plan:
- Reset then idle 300 cycles, DIV=100, en=1: tick at cycles 100/200/300 after release; pgt_1Hz one cycle later; D=0, load=1.
- keys=0x020 held 20 cycles, DEB_CYCLES=4, en=0: exactly one key_strobe 6 cycles after the edge, D=5, held=1, pgt_1Hz one cycle after the strobe. Release gives load=1 6 cycles later.
- Bounce: keys toggles 0x008/0 every 2 cycles for 10 cycles, then stable 0x008: no strobe during bounce, one strobe with D=3 after DEB_CYCLES of stability.
- keys=0x081 simultaneously: D=7. Drop bit 7 during PRESS_DEB: debounce restarts and D=0 is accepted.
- REPEAT_EN=1, DLY=50, RATE=20, hold 0x200 for 150 cycles: strobes at acceptance, +50, +70, +90, +110, +130. D=9 throughout.
- Assert rst during PRESS_DEB and HELD: outputs return to reset values asynchronously with no spurious strobe. A key still held after release is re-accepted after DEB_CYCLES+2.
